nba_merge_collector: RTL and testbench



---
 rtl/nba_merge_pkg.sv | 12 +
 rtl/nba_merge_fifo.sv | 39 +++
 rtl/nba_merge_collector.sv | 64 ++++++
 tb/tb_nba_merge_collector.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/nba_merge_pkg.sv
// nba_merge_pkg: shared merge helper, pointer sizing and counter width for nba_merge_collector
package nba_merge_pkg;
  localparam int MAX_W = 1024;
  localparam int CONF_CNT_W = 16;
  typedef logic [MAX_W-1:0] wide_t;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic wide_t apply_mask(input wide_t x, input wide_t d, input wide_t m);
    return (x & ~m) | (d & m);
  endfunction
endpackage

// File: rtl/nba_merge_fifo.sv
// nba_merge_fifo: DEPTH x WIDTH register FIFO with occupancy count, head read straight from the array
module nba_merge_fifo
  import nba_merge_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/nba_merge_collector.sv
// nba_merge_collector: ordered two-port masked merge into staging, committed into a FIFO; NBA_MERGE_CONFLICT_EN adds conflict outputs
module nba_merge_collector
  import nba_merge_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  parameter int CLEAR_ON_COMMIT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w0_en,
  input  logic [WIDTH-1:0]       w0_data,
  input  logic [WIDTH-1:0]       w0_mask,
  input  logic                   w1_en,
  input  logic [WIDTH-1:0]       w1_data,
  input  logic [WIDTH-1:0]       w1_mask,
  input  logic                   commit,
  output logic                   commit_ready,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  input  logic                   rd_ready,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
`ifdef NBA_MERGE_CONFLICT_EN
  ,
  output logic                   conflict,
  output logic [CONF_CNT_W-1:0]  conflict_cnt
`endif
);
  logic [WIDTH-1:0] stg, m0, m1, mid, merged;
  logic full, empty, pop, push;
  assign m0 = w0_en ? w0_mask : '0;
  assign m1 = w1_en ? w1_mask : '0;
  assign mid = WIDTH'(apply_mask(wide_t'(stg), wide_t'(w0_data), wide_t'(m0)));
  assign merged = WIDTH'(apply_mask(wide_t'(mid), wide_t'(w1_data), wide_t'(m1)));
  assign rd_valid = ~empty;
  assign pop = rd_valid & rd_ready;
  assign commit_ready = ~full | pop;
  assign push = commit & commit_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stg <= '0;
      overflow <= 1'b0;
    end else begin
      stg <= (push && CLEAR_ON_COMMIT != 0) ? '0 : merged;
      overflow <= overflow | (commit & ~commit_ready);
    end
  nba_merge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(merged),
    .dout(rd_data), .full(full), .empty(empty), .count(count)
  );
`ifdef NBA_MERGE_CONFLICT_EN
  logic hit;
  assign hit = w0_en & w1_en & |(w0_mask & w1_mask);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      conflict <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      conflict <= hit;
      conflict_cnt <= conflict_cnt + CONF_CNT_W'(hit && !(&conflict_cnt));
    end
`endif
endmodule

// File: tb/tb_nba_merge_collector.sv
// tb_nba_merge_collector: directed checks of merge order, commit/clear, FIFO fill/wrap, overflow and async reset
module tb_nba_merge_collector;
  logic clk = 1'b0, rst = 1'b1;
  logic w0_en = 0, w1_en = 0, commit = 0, rd_ready = 0;
  logic [127:0] w0_data = '0, w0_mask = '0, w1_data = '0, w1_mask = '0, rd_data;
  logic commit_ready, rd_valid, overflow;
  logic [2:0] count;
  logic b_w0_en = 0, b_commit = 0, b_rd_ready = 0;
  logic [7:0] b_w0_data = '0, b_w0_mask = '0, b_rd_data;
  logic b_commit_ready, b_rd_valid, b_overflow;
  logic [2:0] b_count;
  int n = 0, fails = 0;
`ifdef NBA_MERGE_CONFLICT_EN
  logic conflict, b_conflict;
  logic [15:0] conflict_cnt, b_conflict_cnt;
`endif
  always #5 clk = ~clk;
  nba_merge_collector #(.WIDTH(128), .DEPTH(4), .CLEAR_ON_COMMIT(1)) dut (
    .clk(clk), .rst(rst), .w0_en(w0_en), .w0_data(w0_data), .w0_mask(w0_mask),
    .w1_en(w1_en), .w1_data(w1_data), .w1_mask(w1_mask), .commit(commit),
    .commit_ready(commit_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .overflow(overflow), .count(count)
`ifdef NBA_MERGE_CONFLICT_EN
    , .conflict(conflict), .conflict_cnt(conflict_cnt)
`endif
  );
  nba_merge_collector #(.WIDTH(8), .DEPTH(4), .CLEAR_ON_COMMIT(0)) dut8 (
    .clk(clk), .rst(rst), .w0_en(b_w0_en), .w0_data(b_w0_data), .w0_mask(b_w0_mask),
    .w1_en(1'b0), .w1_data(8'hFF), .w1_mask(8'hFF), .commit(b_commit),
    .commit_ready(b_commit_ready), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .rd_ready(b_rd_ready), .overflow(b_overflow), .count(b_count)
`ifdef NBA_MERGE_CONFLICT_EN
    , .conflict(b_conflict), .conflict_cnt(b_conflict_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr0(input logic en, input logic [127:0] d, input logic [127:0] m, input logic c);
    w0_en = en;
    w0_data = d;
    w0_mask = m;
    commit = c;
  endtask
  initial begin
    w1_data = '0;
    repeat (2) step();
    chk("rst_count", count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_commit_ready", commit_ready, 1);
`ifdef NBA_MERGE_CONFLICT_EN
    chk("rst_conflict", conflict, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
`endif
    rst = 1'b0;
    step();
    wr0(1, '1, 128'hFF, 1);
    w1_en = 1;
    w1_mask = 128'h80;
    step();
    wr0(0, '0, '0, 0);
    w1_en = 0;
    chk("w8_rd_valid", rd_valid, 1);
    chk("w8_rd_data", rd_data, 128'h7F);
    chk("w8_count", count, 1);
    rd_ready = 1;
    step();
    chk("w8_popped", count, 0);
    wr0(1, '1, '1, 1);
    w1_en = 1;
    w1_mask = 128'h1 << 127;
    step();
    chk("b127", rd_data, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    w1_mask = 128'h1 << 63;
    step();
    chk("b63_count", count, 1);
    chk("b63", rd_data, 128'hFFFFFFFF_FFFFFFFF_7FFFFFFF_FFFFFFFF);
    w1_mask = 128'h1 << 64;
    step();
    chk("b64", rd_data, 128'hFFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF);
    wr0(0, '0, '0, 0);
    w1_en = 0;
    w1_mask = '0;
    step();
    chk("drain_count", count, 0);
    chk("drain_valid", rd_valid, 0);
    rd_ready = 0;
    wr0(1, 128'hA5, 128'hFF, 1);
    b_w0_en = 1; b_w0_data = 8'hA5; b_w0_mask = 8'hFF; b_commit = 1;
    step();
    wr0(1, 128'h0F, 128'h0F, 1);
    b_w0_data = 8'h0F; b_w0_mask = 8'h0F;
    step();
    wr0(0, '0, '0, 0);
    b_w0_en = 0; b_commit = 0;
    chk("clr_count", count, 2);
    chk("clr_head0", rd_data, 128'hA5);
    chk("hold_head0", b_rd_data, 8'hA5);
    rd_ready = 1;
    b_rd_ready = 1;
    step();
    chk("clr_head1", rd_data, 128'h0F);
    chk("hold_head1", b_rd_data, 8'hAF);
    step();
    chk("clr_empty", count, 0);
    chk("hold_empty", b_count, 0);
    rd_ready = 0;
    b_rd_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      wr0(1, 128'(k), 128'hFF, 1);
      step();
    end
    wr0(0, '0, '0, 0);
    chk("full_count", count, 4);
    chk("full_ready", commit_ready, 0);
    chk("full_head", rd_data, 128'h1);
    wr0(1, 128'h5, 128'hFF, 1);
    step();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head", rd_data, 128'h1);
    wr0(1, 128'h6, 128'hFF, 1);
    rd_ready = 1;
    #1;
    chk("full_pop_ready", commit_ready, 1);
    step();
    wr0(0, '0, '0, 0);
    chk("fullpp_count", count, 4);
    chk("fullpp_ovf", overflow, 1);
    chk("wrap_0", rd_data, 128'h2);
    step();
    chk("wrap_1", rd_data, 128'h3);
    step();
    chk("wrap_2", rd_data, 128'h4);
    step();
    chk("wrap_3", rd_data, 128'h6);
    step();
    chk("wrap_empty", count, 0);
    rd_ready = 0;
    for (int k = 7; k <= 9; k++) begin
      wr0(1, 128'(k), 128'hFF, 1);
      step();
    end
    wr0(1, 128'h55, 128'hFF, 0);
    step();
    chk("pre_rst_count", count, 3);
    wr0(0, '0, '0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_count", count, 0);
    chk("async_valid", rd_valid, 0);
    chk("async_ovf", overflow, 0);
    #1 rst = 1'b0;
    commit = 1;
    step();
    commit = 0;
    chk("post_rst_valid", rd_valid, 1);
    chk("post_rst_stg", rd_data, 0);
    chk("post_rst_count", count, 1);
`ifdef NBA_MERGE_CONFLICT_EN
    wr0(1, 128'h80, 128'h80, 0);
    w1_en = 1;
    w1_mask = 128'h80;
    step();
    chk("conf_pulse", conflict, 1);
    chk("conf_cnt1", conflict_cnt, 1);
    w0_mask = 128'h0F;
    w1_mask = 128'hF0;
    step();
    chk("conf_clear", conflict, 0);
    chk("conf_cnt_hold", conflict_cnt, 1);
    wr0(0, '0, '0, 0);
    w1_en = 0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
